// File: rtl/shift_pipe_if.sv
// Request/result handshake bundle for shift_pipe.
// The shifter uses the slave modport; the producer/consumer side uses master.
interface shift_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int LOG2W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LOG2W-1:0] in_shamt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: stage k shifts/rotates by 2^k when shamt bit k is set.
// Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROL. Fixed latency of LOG2W edges.
module shift_pipe #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  shift_pipe_if.slave  bus
);
  localparam int LOG2W = $clog2(WIDTH);

  // Handshake: a request transfers on an edge with in_valid && in_ready, a result
  // on an edge with out_valid && out_ready; in_ready depends only on the output side.
  logic adv;

  logic             valid_q [LOG2W];
  logic [WIDTH-1:0] data_q  [LOG2W];
  logic [1:0]       op_q    [LOG2W];
  logic [LOG2W-1:0] shamt_q [LOG2W];
  logic             sign_q  [LOG2W];
  logic             zero_q;

  logic             valid_d [LOG2W];
  logic [WIDTH-1:0] data_d  [LOG2W];
  logic [1:0]       op_d    [LOG2W];
  logic [LOG2W-1:0] shamt_d [LOG2W];
  logic             sign_d  [LOG2W];

  function automatic logic [WIDTH-1:0] stage_fn(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sgn,
    input int unsigned      s
  );
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = (d >> s) | (sgn ? ~({WIDTH{1'b1}} >> s) : '0);
      default: r = (d << s) | (d >> (WIDTH - s));
    endcase
    return r;
  endfunction

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    logic             sv;
    logic [WIDTH-1:0] sd;
    logic [1:0]       so;
    logic [LOG2W-1:0] ss;
    logic             sg;

    if (k == 0) begin : g_first
      // Idle cycles load a clean bubble so ignored inputs never reach the pipe.
      assign sv = bus.in_valid;
      assign sd = bus.in_valid ? bus.in_data : '0;
      assign so = bus.in_valid ? bus.in_op : 2'b00;
      assign ss = bus.in_valid ? bus.in_shamt : '0;
      assign sg = bus.in_valid & bus.in_data[WIDTH-1];
    end else begin : g_rest
      assign sv = valid_q[k-1];
      assign sd = data_q[k-1];
      assign so = op_q[k-1];
      assign ss = shamt_q[k-1];
      assign sg = sign_q[k-1];
    end

    assign valid_d[k] = sv;
    assign data_d[k]  = ss[k] ? stage_fn(sd, so, sg, 32'(1) << k) : sd;
    assign op_d[k]    = so;
    assign shamt_d[k] = ss & ~(LOG2W'(1) << k);
    assign sign_d[k]  = sg;
  end

  assign adv = !valid_q[LOG2W-1] || bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LOG2W; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        op_q[k]    <= 2'b00;
        shamt_q[k] <= '0;
        sign_q[k]  <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < LOG2W; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        op_q[k]    <= op_d[k];
        shamt_q[k] <= shamt_d[k];
        sign_q[k]  <= sign_d[k];
      end
      zero_q <= (data_d[LOG2W-1] == '0);
    end
  end

  // The last stage's control fields travel along but nothing downstream needs them.
  logic unused_tail;
  assign unused_tail = ^{op_q[LOG2W-1], shamt_q[LOG2W-1], sign_q[LOG2W-1]};

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[LOG2W-1];
  assign bus.out_data  = data_q[LOG2W-1];
  assign bus.out_zero  = zero_q;
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter for the execute stage. It supersedes the fixed shift-left-by-2 branch-offset shifter: that function is one case here (SLL, shamt=2). The block adds run-time amount, four shift modes, a zero flag and a valid/ready handshake. It sits between the operand-forwarding muxes and the EX/MEM register, giving one result per cycle at a fixed latency.

## Interface
- WIDTH, 32, data width; must be a power of two, ≥ 4
- LOG2W, $clog2(WIDTH), localparam; shift-amount width and pipeline depth
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  LOG2W  shift amount, 0..WIDTH-1
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  shifted result
- out_zero  output  1  out_data == 0

## Operation
- The block has LOG2W register stages, S0..S(LOG2W-1).
- Stage k applies shift/rotate by 2^k when shamt bit k = 1; otherwise it passes the data through.
- Each stage register holds: valid, data, op, remaining shamt bits, and the sign bit.
- The sign bit is in_data[WIDTH-1], captured at accept.
- Fill rules per stage:
  - SLL: fill zeros at the LSBs.
  - SRL: fill zeros at the MSBs.
  - SRA: fill with the captured sign bit.
  - ROL: bits leaving the MSB end re-enter at the LSB.
- out_zero is computed in the final stage from that stage's result and registered with it.
- The last stage drives out_data, out_valid and out_zero directly; there is no combinational output logic.
- Global advance: adv = !out_valid || out_ready.
  - When adv = 1, every stage loads from its predecessor, and S0 loads from the inputs.
  - When adv = 0, every stage holds.
- in_ready = adv. A request is accepted on an edge where in_valid && in_ready.
- A cycle with in_valid = 0 and adv = 1 inserts a bubble (valid = 0) into S0. Bubbles are not collapsed.
- in_data, in_op and in_shamt are ignored when in_valid = 0.
- shamt = 0 returns in_data unchanged in every mode.

## Timing
- Reset: every stage valid, data, op, shamt and sign field clears to 0.
  - out_valid = 0, out_data = 0, out_zero = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Latency: a request accepted on edge N appears on the outputs after edge N+LOG2W-1 (LOG2W edges, counting N). For WIDTH=32 that is 5.
- Throughput: one result per cycle while out_ready = 1.
- Back-pressure: if out_valid = 1 and out_ready = 0, all stages, outputs and in_ready (= 0) hold until out_ready rises. No request is lost or duplicated.
- A result is consumed on an edge where out_valid && out_ready.
- Simultaneous consume and accept is legal with the pipe full; the pipeline shifts by one.
- Reset asserted mid-operation discards every in-flight request. On the next edge the outputs take their reset values.
- in_ready is a function of out_valid and out_ready only, never of in_valid, so there is no combinational input-to-input loop.

## Test plan
- After reset, drive in_valid=1, in_op=SLL, in_shamt=2, in_data=0x0000_0001 (WIDTH=32), out_ready=1 → out_valid=1 exactly 5 edges later, out_data=0x0000_0004, out_zero=0.
- SRA 0x8000_0000 by 31 → 0xFFFF_FFFF. SRL 0x8000_0000 by 31 → 0x0000_0001. ROL 0x8000_0001 by 1 → 0x0000_0003. SLL 0x0000_0001 by 0 → 0x0000_0001.
- SLL 0xFFFF_FFFF by 31 → 0x8000_0000. SRL 0x0000_0001 by 1 → 0x0000_0000 with out_zero=1.
- Stream 10 back-to-back requests with out_ready=1, then hold out_ready=0 for 7 cycles.
  - Required: in_ready=0 and outputs stable during the hold.
  - After release: all 10 results emerge in order with correct values, with no drops or duplicates.
- Random op/shamt/data (≥10k vectors) with random in_valid/out_ready gaps, checked against a reference model scoreboard → zero mismatches.
- Assert reset while 3 requests are in flight → outputs 0 and out_valid=0 on the next edge, and no stale result emerges afterwards.
